cpu2core_sysid_checker: RTL and testbench

CPU2CORE_SYSID_CHECKER -- requirements
Module: cpu2core_sysid_checker

---
 rtl/cpu2core_sysid_pkg.sv | 44 ++++
 rtl/cpu2core_wait_timer.sv | 40 ++++
 rtl/cpu2core_sysid_checker.sv | 156 +++++++++++++++
 tb/tb_cpu2core_sysid_checker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu2core_sysid_pkg.sv
// ---------------------------------------------------------------------------
// cpu2core_sysid_pkg
//   Shared definitions for the sysid checker: FSM state encoding, result
//   codes reported on err_code, the default expected sysid contents and a
//   helper that classifies a captured (id, timestamp) pair.
//
//   No ports (package).
// ---------------------------------------------------------------------------
package cpu2core_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_ID = 3'd1,
    ST_RD_TS = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ID      = 2'd1;
  localparam logic [1:0] ERR_TS      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [31:0] DEFAULT_ID = 32'd0;
  localparam logic [31:0] DEFAULT_TS = 32'd1446731318;

  // An ID mismatch takes priority over a timestamp mismatch.
  function automatic logic [1:0] classify_sysid(
    input logic [31:0] id,
    input logic [31:0] ts,
    input logic [31:0] exp_id,
    input logic [31:0] exp_ts
  );
    logic [1:0] code;
    code = ERR_OK;
    if (id != exp_id) begin
      code = ERR_ID;
    end else if (ts != exp_ts) begin
      code = ERR_TS;
    end
    return code;
  endfunction

endpackage

// File: rtl/cpu2core_wait_timer.sv
// ---------------------------------------------------------------------------
// cpu2core_wait_timer
//   16-bit stall counter for one Avalon-MM read. Counts cycles with enable
//   high; expired flags the cycle in which the limit-th stall is seen, so
//   the owner can abandon the read on that same edge.
//
//   Ports:
//     clock   in   sole clock, rising edge
//     reset   in   synchronous, active-high
//     clear   in   return count to zero (has priority over enable)
//     enable  in   current cycle is a stalled read cycle
//     limit   in   16  number of stall cycles tolerated
//     expired out  this stall cycle reaches the limit
// ---------------------------------------------------------------------------
module cpu2core_wait_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic        expired
);

  logic [15:0] count;
  logic [15:0] count_inc;

  assign count_inc = count + 16'd1;

  // count holds the stalls already seen; count_inc includes the current one.
  assign expired = enable && (count_inc >= limit);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= 16'd0;
    end else if (enable && !expired) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/cpu2core_sysid_checker.sv
// ---------------------------------------------------------------------------
// cpu2core_sysid_checker
//   Reads sysid word 0 (system ID) and word 1 (build timestamp) over an
//   Avalon-MM master port, compares them against the expected values and
//   reports the result. A check runs on a start pulse, or automatically
//   once after reset when AUTO_START is set.
//
//   Ports:
//     clock            in   sole clock, rising edge
//     reset            in   synchronous, active-high
//     start            in   single-cycle check request (ignored while busy)
//     avm_address      out  sysid word select (0 = ID, 1 = timestamp)
//     avm_read         out  read strobe
//     avm_readdata     in   32  read data
//     avm_waitrequest  in   slave stall
//     busy             out  check in progress
//     done             out  one-cycle completion pulse
//     pass             out  result of last completed check
//     err_code         out  2   0 ok, 1 ID, 2 timestamp, 3 timeout
//     id_out, ts_out   out  32  captured sysid words
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_IDLE  | waiting for start or the pending auto-start
//   ST_RD_ID | reading word 0, capture into id_out on accept
//   ST_RD_TS | reading word 1, capture into ts_out on accept
//   ST_CHECK | compare captured words, latch err_code/pass
//   ST_DONE  | done pulse high, then back to idle
// ---------------------------------------------------------------------------
module cpu2core_sysid_checker
  import cpu2core_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_TS,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  err_code,
  output logic [31:0] id_out,
  output logic [31:0] ts_out
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t     state;
  logic       auto_pending;
  logic       reading;
  logic       accept;
  logic       stall;
  logic       timeout_hit;
  logic [1:0] check_result;

  assign reading      = (state == ST_RD_ID) || (state == ST_RD_TS);
  assign accept       = reading && !avm_waitrequest;
  assign stall        = reading && avm_waitrequest;
  assign check_result = classify_sysid(id_out, ts_out, EXPECTED_ID, EXPECTED_TS);

  // Stall budget is per read: cleared outside the read states and whenever
  // a read is accepted, so the timestamp read gets a fresh budget.
  cpu2core_wait_timer u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (!reading || accept),
    .enable  (stall),
    .limit   (TIMEOUT_LIMIT),
    .expired (timeout_hit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      auto_pending <= AUTO_START;
      avm_read     <= 1'b0;
      avm_address  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_code     <= ERR_OK;
      id_out       <= 32'd0;
      ts_out       <= 32'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start || auto_pending) begin
            state        <= ST_RD_ID;
            auto_pending <= 1'b0;
            avm_read     <= 1'b1;
            avm_address  <= 1'b0;
            busy         <= 1'b1;
          end
        end

        ST_RD_ID: begin
          if (accept) begin
            id_out      <= avm_readdata;
            avm_address <= 1'b1;
            state       <= ST_RD_TS;
          end else if (timeout_hit) begin
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            busy        <= 1'b0;
            err_code    <= ERR_TIMEOUT;
            pass        <= 1'b0;
            done        <= 1'b1;
            state       <= ST_DONE;
          end
        end

        ST_RD_TS: begin
          if (accept) begin
            ts_out      <= avm_readdata;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            state       <= ST_CHECK;
          end else if (timeout_hit) begin
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            busy        <= 1'b0;
            err_code    <= ERR_TIMEOUT;
            pass        <= 1'b0;
            done        <= 1'b1;
            state       <= ST_DONE;
          end
        end

        ST_CHECK: begin
          err_code <= check_result;
          pass     <= (check_result == ERR_OK);
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= ST_DONE;
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu2core_sysid_checker.sv
// ---------------------------------------------------------------------------
// tb_cpu2core_sysid_checker
//   Directed bench: a small sysid slave model with programmable stall
//   length drives the checker through pass, mismatch, stall, timeout,
//   mid-read reset and start-while-busy scenarios.
// ---------------------------------------------------------------------------
module tb_cpu2core_sysid_checker;

  localparam logic [31:0] TS_GOOD = 32'd1446731318;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  err_code;
  logic [31:0] id_out;
  logic [31:0] ts_out;

  logic [31:0] word0 = 32'd0;
  logic [31:0] word1 = TS_GOOD;
  int          stall_len = 0;
  int          stall_cnt = 0;

  int vec_cnt = 0;
  int miscmp  = 0;

  always #5 clock = ~clock;

  // sysid slave model: each read is stalled for stall_len cycles
  assign avm_readdata    = avm_address ? word1 : word0;
  assign avm_waitrequest = avm_read && (stall_cnt < stall_len);

  always @(posedge clock) begin
    if (avm_read && avm_waitrequest) stall_cnt <= stall_cnt + 1;
    else                             stall_cnt <= 0;
  end

  cpu2core_sysid_checker #(
    .TIMEOUT_CYCLES (8),
    .AUTO_START     (1'b1)
  ) u_dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_code        (err_code),
    .id_out          (id_out),
    .ts_out          (ts_out)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // cycles counts edges from the one that samples start (or the first edge
  // after reset release) up to and including the edge that raises done.
  task automatic run_until_done(input int budget, output int cycles, output int read_hi);
    logic prev_addr;
    logic prev_stall;
    cycles  = 0;
    read_hi = 0;
    do begin
      prev_addr  = avm_address;
      prev_stall = avm_read && avm_waitrequest;
      tick();
      cycles++;
      start = 1'b0;
      if (avm_read) read_hi++;
      if (prev_stall && avm_read) check_val("addr_stable", 32'(avm_address), 32'(prev_addr));
    end while (!done && cycles < budget);
    check_val("done_seen", 32'(done), 32'd1);
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done) pulses++;
    end
  endtask

  initial begin
    int cyc;
    int rd;
    int pulses;

    // reset state
    reset = 1'b1;
    repeat (3) tick();
    check_val("rst_read",  32'(avm_read),    32'd0);
    check_val("rst_addr",  32'(avm_address), 32'd0);
    check_val("rst_busy",  32'(busy),        32'd0);
    check_val("rst_done",  32'(done),        32'd0);
    check_val("rst_pass",  32'(pass),        32'd0);
    check_val("rst_err",   32'(err_code),    32'd0);
    check_val("rst_id",    id_out,           32'd0);
    check_val("rst_ts",    ts_out,           32'd0);

    // auto-start, zero wait, matching sysid
    reset = 1'b0;
    run_until_done(20, cyc, rd);
    check_val("auto_latency", 32'(cyc),      32'd4);
    check_val("auto_pass",    32'(pass),     32'd1);
    check_val("auto_err",     32'(err_code), 32'd0);
    check_val("auto_ts",      ts_out,        TS_GOOD);
    check_val("auto_id",      id_out,        32'd0);
    check_val("auto_busy",    32'(busy),     32'd0);
    tick();
    check_val("done_one_cycle", 32'(done),   32'd0);
    tick();

    // ID mismatch
    word0 = 32'd1;
    start = 1'b1;
    run_until_done(20, cyc, rd);
    check_val("id_mis_latency", 32'(cyc),      32'd4);
    check_val("id_mis_err",     32'(err_code), 32'd1);
    check_val("id_mis_pass",    32'(pass),     32'd0);
    check_val("id_mis_id",      id_out,        32'd1);
    tick(); tick();

    // timestamp mismatch
    word0 = 32'd0;
    word1 = 32'd0;
    start = 1'b1;
    run_until_done(20, cyc, rd);
    check_val("ts_mis_err",  32'(err_code), 32'd2);
    check_val("ts_mis_pass", 32'(pass),     32'd0);
    check_val("ts_mis_ts",   ts_out,        32'd0);
    tick(); tick();

    // three stall cycles per read
    word1     = TS_GOOD;
    stall_len = 3;
    start     = 1'b1;
    run_until_done(30, cyc, rd);
    check_val("stall_latency", 32'(cyc),      32'd10);
    check_val("stall_pass",    32'(pass),     32'd1);
    check_val("stall_err",     32'(err_code), 32'd0);
    tick(); tick();

    // waitrequest stuck high: timeout after 8 stalled cycles
    stall_len = 1000;
    start     = 1'b1;
    run_until_done(40, cyc, rd);
    check_val("to_read_cycles", 32'(rd),       32'd8);
    check_val("to_latency",     32'(cyc),      32'd9);
    check_val("to_err",         32'(err_code), 32'd3);
    check_val("to_pass",        32'(pass),     32'd0);
    check_val("to_read_low",    32'(avm_read), 32'd0);
    count_done(10, pulses);
    check_val("to_extra_done",  32'(pulses),   32'd0);

    // reset while stalled in the timestamp read
    stall_len = 3;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && !(avm_read && avm_address); i++) tick();
    check_val("reached_rd_ts", 32'(avm_read && avm_address), 32'd1);
    reset = 1'b1;
    tick();
    check_val("mid_rst_read", 32'(avm_read), 32'd0);
    check_val("mid_rst_busy", 32'(busy),     32'd0);
    check_val("mid_rst_err",  32'(err_code), 32'd0);
    check_val("mid_rst_pass", 32'(pass),     32'd0);
    check_val("mid_rst_ts",   ts_out,        32'd0);
    check_val("mid_rst_done", 32'(done),     32'd0);
    stall_len = 0;
    reset     = 1'b0;
    run_until_done(20, cyc, rd);
    check_val("rerun_latency", 32'(cyc),  32'd4);
    check_val("rerun_pass",    32'(pass), 32'd1);
    check_val("rerun_ts",      ts_out,    TS_GOOD);
    tick(); tick();

    // start pulsed while the ID read is stalled must be dropped
    stall_len = 3;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    run_until_done(30, cyc, rd);
    check_val("dup_latency", 32'(cyc),  32'd8);
    check_val("dup_pass",    32'(pass), 32'd1);
    stall_len = 0;
    count_done(10, pulses);
    check_val("dup_extra_done", 32'(pulses), 32'd0);

    // a fresh start in idle runs a second check
    word0 = 32'd1;
    start = 1'b1;
    run_until_done(20, cyc, rd);
    check_val("second_latency", 32'(cyc),      32'd4);
    check_val("second_err",     32'(err_code), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
